rv_toggle_responder: RTL and testbench

- Responder end of the RISC-V softcore's toggle request/acknowledge memory port (rv_req / rv_req_ack, 16-bit halfword accesses with byte strobes).
- Sits in the SDRAM clock domain in front of the memory backend.
- Detects a new request when rv_req differs from rv_req_ack, latches it, and issues it to a generic valid/ready memory port only in the allotted time slot.
- Returns read data, then toggles rv_req_ack; includes a read timeout so a hung backend cannot deadlock iosys.

---
 rtl/rv_toggle_responder_if.sv | 40 ++++
 rtl/rv_toggle_responder.sv | 195 +++++++++++++++++++
 tb/tb_rv_toggle_responder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_toggle_responder_if.sv
// Bundle of the toggle request/ack port facing the RISC-V initiator and the
// valid/ready memory port facing the backend, plus slot and status signals.
//   slave  : responder view (rv_* requests in, mem_* requests out)
//   master : environment view (initiator + backend + slot arbiter)
interface rv_toggle_responder_if #(
   parameter int unsigned ADDR_W = 20
);
   logic              rv_req;
   logic              rv_req_ack;
   logic [ADDR_W-1:0] rv_addr;
   logic              rv_we;
   logic [1:0]        rv_ds;
   logic [15:0]       rv_din;
   logic [15:0]       rv_dout;
   logic              slot_en;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [1:0]        mem_be;
   logic [15:0]       mem_wdata;
   logic              mem_rvalid;
   logic [15:0]       mem_rdata;
   logic              busy;
   logic              timeout_err;

   modport slave (
      input  rv_req, rv_addr, rv_we, rv_ds, rv_din, slot_en,
             mem_ready, mem_rvalid, mem_rdata,
      output rv_req_ack, rv_dout, mem_valid, mem_addr, mem_we, mem_be,
             mem_wdata, busy, timeout_err
   );

   modport master (
      output rv_req, rv_addr, rv_we, rv_ds, rv_din, slot_en,
             mem_ready, mem_rvalid, mem_rdata,
      input  rv_req_ack, rv_dout, mem_valid, mem_addr, mem_we, mem_be,
             mem_wdata, busy, timeout_err
   );
endinterface

// File: rtl/rv_toggle_responder.sv
// Responder for the RISC-V toggle request/ack halfword memory port.
// A request is pending whenever rv_req differs from rv_req_ack; it is latched,
// issued once to the valid/ready backend inside an allowed slot, and completed
// by toggling rv_req_ack. Reads are guarded by a timeout so a hung backend
// cannot stall the initiator forever.
// Ports:
//   clk     : SDRAM-domain clock
//   resetn  : synchronous active-low reset
//   bus     : rv_toggle_responder_if.slave (rv_* initiator side, mem_* backend
//             side, slot_en, busy, sticky timeout_err)
module rv_toggle_responder #(
   parameter int unsigned ADDR_W       = 20,
   parameter int unsigned READ_TIMEOUT = 255,
   parameter logic [15:0] TIMEOUT_DATA = 16'hFFFF
) (
   input logic                  clk,
   input logic                  resetn,
   rv_toggle_responder_if.slave bus
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = 2;
   localparam int unsigned CNT_W  = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_RDWAIT = 2'd2,
      S_ACK    = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic              ack_q,      ack_d;
   logic              busy_q,     busy_d;
   logic [DATA_W-1:0] dout_q,     dout_d;
   logic              terr_q,     terr_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              mvalid_q,   mvalid_d;
   logic [ADDR_W-1:0] maddr_q,    maddr_d;
   logic              mwe_q,      mwe_d;
   logic [BE_W-1:0]   mbe_q,      mbe_d;
   logic [DATA_W-1:0] mwdata_q,   mwdata_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic              lat_we_q,   lat_we_d;
   logic [BE_W-1:0]   lat_ds_q,   lat_ds_d;
   logic [DATA_W-1:0] lat_din_q,  lat_din_d;

   logic              pending_c;
   logic              handshake_c;
   logic              timeout_c;
   logic [CNT_W-1:0]  cnt_inc_c;

   // Request detection, backend handshake and read timeout decode.
   assign pending_c   = (bus.rv_req != ack_q);
   assign handshake_c = mvalid_q & bus.mem_ready;
   assign cnt_inc_c   = cnt_q + CNT_W'(1);
   assign timeout_c   = (READ_TIMEOUT != 0) && (cnt_inc_c == CNT_W'(READ_TIMEOUT));

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic. A null-strobe request spends one ISSUE cycle without
   // touching the backend so its ack lands one cycle ahead of a write.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (pending_c) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (lat_ds_q == '0)   state_d = S_ACK;
            else if (handshake_c) state_d = lat_we_q ? S_ACK : S_RDWAIT;
         end
         S_RDWAIT: begin
            if (bus.mem_rvalid || timeout_c) state_d = S_ACK;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values for every registered output and request latch.
   always_comb begin
      ack_d      = ack_q;
      busy_d     = busy_q;
      dout_d     = dout_q;
      terr_d     = terr_q;
      cnt_d      = cnt_q;
      mvalid_d   = mvalid_q;
      maddr_d    = maddr_q;
      mwe_d      = mwe_q;
      mbe_d      = mbe_q;
      mwdata_d   = mwdata_q;
      lat_addr_d = lat_addr_q;
      lat_we_d   = lat_we_q;
      lat_ds_d   = lat_ds_q;
      lat_din_d  = lat_din_q;

      unique case (state_q)
         S_IDLE: begin
            if (pending_c) begin
               lat_addr_d = bus.rv_addr;
               lat_we_d   = bus.rv_we;
               lat_ds_d   = bus.rv_ds;
               lat_din_d  = bus.rv_din;
               busy_d     = 1'b1;
            end
         end
         S_ISSUE: begin
            // Once valid is up, hold everything until the backend accepts.
            if (mvalid_q) begin
               if (bus.mem_ready) begin
                  mvalid_d = 1'b0;
                  cnt_d    = '0;
               end
            end else if ((lat_ds_q != '0) && bus.slot_en) begin
               mvalid_d = 1'b1;
               maddr_d  = lat_addr_q;
               mwe_d    = lat_we_q;
               mbe_d    = lat_we_q ? lat_ds_q : BE_W'(2'b11);
               mwdata_d = lat_din_q;
            end
         end
         S_RDWAIT: begin
            // Real data takes priority over a timeout in the same cycle.
            if (bus.mem_rvalid) begin
               dout_d = bus.mem_rdata;
            end else begin
               cnt_d = cnt_inc_c;
               if (timeout_c) begin
                  dout_d = TIMEOUT_DATA;
                  terr_d = 1'b1;
               end
            end
         end
         S_ACK: begin
            ack_d  = ~ack_q;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Output and latch registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         dout_q     <= '0;
         terr_q     <= 1'b0;
         cnt_q      <= '0;
         mvalid_q   <= 1'b0;
         maddr_q    <= '0;
         mwe_q      <= 1'b0;
         mbe_q      <= '0;
         mwdata_q   <= '0;
         lat_addr_q <= '0;
         lat_we_q   <= 1'b0;
         lat_ds_q   <= '0;
         lat_din_q  <= '0;
      end else begin
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         dout_q     <= dout_d;
         terr_q     <= terr_d;
         cnt_q      <= cnt_d;
         mvalid_q   <= mvalid_d;
         maddr_q    <= maddr_d;
         mwe_q      <= mwe_d;
         mbe_q      <= mbe_d;
         mwdata_q   <= mwdata_d;
         lat_addr_q <= lat_addr_d;
         lat_we_q   <= lat_we_d;
         lat_ds_q   <= lat_ds_d;
         lat_din_q  <= lat_din_d;
      end
   end

   assign bus.rv_req_ack  = ack_q;
   assign bus.rv_dout     = dout_q;
   assign bus.mem_valid   = mvalid_q;
   assign bus.mem_addr    = maddr_q;
   assign bus.mem_we      = mwe_q;
   assign bus.mem_be      = mbe_q;
   assign bus.mem_wdata   = mwdata_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_rv_toggle_responder.sv
// Self-checking bench for rv_toggle_responder: a behavioural backend with
// programmable ready/read-data delays and a shadow memory model predicting
// rv_dout, latency, handshakes and the sticky timeout flag.
module tb_rv_toggle_responder;

   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned TO      = 8;
   localparam logic [15:0] TO_DATA = 16'hFFFF;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   rv_toggle_responder_if #(.ADDR_W(ADDR_W)) bus ();

   rv_toggle_responder #(
      .ADDR_W      (ADDR_W),
      .READ_TIMEOUT(TO),
      .TIMEOUT_DATA(TO_DATA)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Backend knobs
   int rdy_dly       = 0;
   int rv_dly        = 1;
   bit rv_never      = 1'b0;
   bit slot_rand     = 1'b0;
   bit slot_force    = 1'b1;
   bit inject_rvalid = 1'b0;

   // Backend state and observations
   logic [15:0]       bmem [256];
   int                vcnt = 0;
   bit                rd_pend = 1'b0;
   int                rd_cd = 0;
   logic [15:0]       rd_data;
   int                hs_cnt = 0;
   int                valid_cycles = 0;
   int                stab_viol = 0;
   logic [ADDR_W-1:0] hs_addr;
   logic              hs_we;
   logic [1:0]        hs_be;
   logic [15:0]       hs_wdata;
   logic [ADDR_W+18:0] snap;

   // Reference model state
   logic [15:0] exp_mem [256];
   logic [15:0] exp_dout = 16'h0000;
   bit          exp_terr = 1'b0;

   // Backend: drives ready, read data and slot at negedge for the next posedge.
   always @(negedge clk) begin
      if (!resetn) begin
         bus.mem_ready  = 1'b0;
         bus.mem_rvalid = 1'b0;
         rd_pend        = 1'b0;
         vcnt           = 0;
         bus.slot_en    = slot_force;
      end else begin
         bus.mem_rvalid = 1'b0;
         if (inject_rvalid) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 16'h5A5A;
         end else if (rd_pend) begin
            rd_cd = rd_cd - 1;
            if (rd_cd <= 0) begin
               rd_pend        = 1'b0;
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = rd_data;
            end
         end
         bus.mem_ready = 1'b0;
         if (bus.mem_valid) begin
            valid_cycles++;
            if (vcnt == 0)
               snap = {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata};
            else if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata} !== snap)
               stab_viol++;
            if (vcnt >= rdy_dly) begin
               bus.mem_ready = 1'b1;
               hs_cnt++;
               hs_addr  = bus.mem_addr;
               hs_we    = bus.mem_we;
               hs_be    = bus.mem_be;
               hs_wdata = bus.mem_wdata;
               if (bus.mem_we) begin
                  if (bus.mem_be[0]) bmem[bus.mem_addr[7:0]][7:0]  = bus.mem_wdata[7:0];
                  if (bus.mem_be[1]) bmem[bus.mem_addr[7:0]][15:8] = bus.mem_wdata[15:8];
               end else if (!rv_never) begin
                  rd_pend = 1'b1;
                  rd_cd   = rv_dly;
                  rd_data = bmem[bus.mem_addr[7:0]];
               end
               vcnt = 0;
            end else begin
               vcnt++;
            end
         end else begin
            vcnt = 0;
         end
         bus.slot_en = slot_rand ? 1'($urandom_range(0, 1)) : slot_force;
      end
   end

   task automatic start_req(input logic [ADDR_W-1:0] a, input logic we,
                            input logic [1:0] ds, input logic [15:0] din);
      @(negedge clk);
      bus.rv_addr = a;
      bus.rv_we   = we;
      bus.rv_ds   = ds;
      bus.rv_din  = din;
      bus.rv_req  = ~bus.rv_req;
   endtask

   task automatic wait_ack(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.rv_req_ack === bus.rv_req) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   // One request through the model and the DUT, checked field by field.
   task automatic run_txn(input string name, input logic [ADDR_W-1:0] a, input logic we,
                          input logic [1:0] ds, input logic [15:0] din, input int exp_lat);
      int   lat;
      bit   ok;
      int   hs0, vc0, exp_hs;
      logic [1:0] exp_be;
      hs0 = hs_cnt;
      vc0 = valid_cycles;
      exp_hs = (ds != 2'b00) ? 1 : 0;
      exp_be = we ? ds : 2'b11;
      if (ds != 2'b00) begin
         if (we) begin
            if (ds[0]) exp_mem[a[7:0]][7:0]  = din[7:0];
            if (ds[1]) exp_mem[a[7:0]][15:8] = din[15:8];
         end else if (rv_never || rv_dly > int'(TO)) begin
            exp_dout = TO_DATA;
            exp_terr = 1'b1;
         end else begin
            exp_dout = exp_mem[a[7:0]];
         end
      end
      start_req(a, we, ds, din);
      wait_ack(lat, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s ack_timeout: ack=%b req=%b", name, bus.rv_req_ack, bus.rv_req);
      end
      if (exp_lat >= 0) begin
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
         end
      end
      checks++;
      if (bus.rv_dout !== exp_dout) begin
         errors++;
         $display("FAIL %s rv_dout: got %h expected %h", name, bus.rv_dout, exp_dout);
      end
      checks++;
      if (bus.timeout_err !== exp_terr || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s status: terr=%b busy=%b expected terr=%b busy=0",
                  name, bus.timeout_err, bus.busy, exp_terr);
      end
      checks++;
      if (hs_cnt - hs0 !== exp_hs) begin
         errors++;
         $display("FAIL %s handshakes: got %0d expected %0d", name, hs_cnt - hs0, exp_hs);
      end
      if (ds != 2'b00) begin
         checks++;
         if (hs_addr !== a || hs_we !== we || hs_be !== exp_be || (we && hs_wdata !== din)) begin
            errors++;
            $display("FAIL %s mem_fields: addr=%h we=%b be=%b wdata=%h expected %h %b %b %h",
                     name, hs_addr, hs_we, hs_be, hs_wdata, a, we, exp_be, din);
         end
         checks++;
         if (valid_cycles - vc0 !== rdy_dly + 1) begin
            errors++;
            $display("FAIL %s valid_cycles: got %0d expected %0d",
                     name, valid_cycles - vc0, rdy_dly + 1);
         end
      end
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      bus.rv_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.rv_req_ack, bus.rv_dout, bus.mem_valid, bus.mem_we, bus.mem_be, bus.mem_addr,
           bus.mem_wdata, bus.busy, bus.timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_values: ack=%b dout=%h valid=%b we=%b be=%b addr=%h wdata=%h busy=%b terr=%b expected all 0",
                  bus.rv_req_ack, bus.rv_dout, bus.mem_valid, bus.mem_we, bus.mem_be,
                  bus.mem_addr, bus.mem_wdata, bus.busy, bus.timeout_err);
      end
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.rv_req_ack !== 1'b0 || bus.busy !== 1'b0 || bus.mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ack=%b busy=%b valid=%b expected 0 0 0",
                  bus.rv_req_ack, bus.busy, bus.mem_valid);
      end
   endtask

   task automatic test_write();
      run_txn("write", 20'h01234, 1'b1, 2'b11, 16'hBEEF, 3);
   endtask

   task automatic test_read();
      run_txn("read", 20'h01234, 1'b0, 2'b01, 16'h0000, 4);
   endtask

   task automatic test_null_strobes();
      run_txn("null_write", 20'h00077, 1'b1, 2'b00, 16'h1111, 2);
      run_txn("null_read", 20'h01234, 1'b0, 2'b00, 16'h0000, 2);
   endtask

   task automatic test_slot_gating();
      int   bad = 0;
      int   hs0, vc0, sv0, lat;
      bit   ok, seen = 1'b0;
      slot_force = 1'b0;
      rdy_dly    = 3;
      hs0 = hs_cnt;
      vc0 = valid_cycles;
      sv0 = stab_viol;
      exp_mem[8'h56] = 16'hCAFE;
      start_req(20'h00056, 1'b1, 2'b11, 16'hCAFE);
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.mem_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL slot_gate_valid: valid high %0d cycles while slot_en=0, expected 0", bad);
      end
      slot_force = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.mem_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      slot_force = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL slot_gate_assert: mem_valid=%b after slot_en=1, expected 1", bus.mem_valid);
      end
      wait_ack(lat, ok);
      checks++;
      if (!ok || hs_cnt - hs0 !== 1 || valid_cycles - vc0 !== 4 || stab_viol !== sv0) begin
         errors++;
         $display("FAIL slot_gate_hold: ok=%b hs=%0d valid_cycles=%0d stab_viol=%0d expected 1 1 4 0",
                  ok, hs_cnt - hs0, valid_cycles - vc0, stab_viol - sv0);
      end
      checks++;
      if (hs_addr !== 20'h00056 || hs_be !== 2'b11 || hs_wdata !== 16'hCAFE) begin
         errors++;
         $display("FAIL slot_gate_fields: addr=%h be=%b wdata=%h expected 00056 11 cafe",
                  hs_addr, hs_be, hs_wdata);
      end
      slot_force = 1'b1;
      rdy_dly    = 0;
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a1 = 20'h00042;
      logic [15:0]       d1;
      logic              prev;
      int                n = 0, t1 = -1, t2 = -1, hs0;
      d1 = ~exp_mem[8'h42];
      exp_mem[8'h42] = d1;
      exp_dout = d1;
      hs0 = hs_cnt;
      start_req(a1, 1'b1, 2'b11, d1);
      start_req(a1, 1'b0, 2'b10, 16'h0000);
      prev = bus.rv_req_ack;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (bus.rv_req_ack !== prev) begin
            prev = bus.rv_req_ack;
            n++;
            if (n == 1) t1 = i;
            else begin
               t2 = i;
               break;
            end
         end
      end
      checks++;
      if (t1 != 3 || t2 != 8) begin
         errors++;
         $display("FAIL b2b_timing: acks at %0d and %0d expected 3 and 8", t1, t2);
      end
      checks++;
      if (bus.rv_dout !== d1 || hs_cnt - hs0 !== 2 || bus.rv_req_ack !== bus.rv_req) begin
         errors++;
         $display("FAIL b2b_result: dout=%h hs=%0d ack=%b req=%b expected %h 2 equal",
                  bus.rv_dout, hs_cnt - hs0, bus.rv_req_ack, bus.rv_req, d1);
      end
   endtask

   task automatic test_timeout();
      rv_dly = int'(TO);
      run_txn("rdata_at_timeout", 20'h00042, 1'b0, 2'b11, 16'h0000, 2 + int'(TO) + 1);
      rv_dly   = 1;
      rv_never = 1'b1;
      run_txn("timeout", 20'h00056, 1'b0, 2'b11, 16'h0000, 2 + int'(TO) + 1);
      rv_never = 1'b0;
      run_txn("read_after_timeout", 20'h00056, 1'b0, 2'b01, 16'h0000, 4);
   endtask

   task automatic test_reset_mid_read();
      int bad = 0;
      rv_never = 1'b1;
      start_req(20'h01234, 1'b0, 2'b11, 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      resetn     = 1'b0;
      bus.rv_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn        = 1'b1;
      rv_never      = 1'b0;
      inject_rvalid = 1'b1;
      @(posedge clk); #1;
      inject_rvalid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if ({bus.rv_req_ack, bus.rv_dout, bus.mem_valid, bus.busy, bus.timeout_err} !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_mid_read: %0d cycles with non-reset outputs, ack=%b dout=%h terr=%b expected 0",
                  bad, bus.rv_req_ack, bus.rv_dout, bus.timeout_err);
      end
      exp_dout = 16'h0000;
      exp_terr = 1'b0;
      run_txn("read_after_reset", 20'h01234, 1'b0, 2'b11, 16'h0000, 4);
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      slot_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rdy_dly = int'($urandom_range(0, 3));
         rv_dly  = int'($urandom_range(1, 5));
         a = {12'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         run_txn("random", a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 16'($urandom), -1);
      end
      slot_rand = 1'b0;
      rdy_dly   = 0;
      rv_dly    = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         exp_mem[i] = 16'($urandom);
         bmem[i]    = exp_mem[i];
      end
      resetn         = 1'b0;
      bus.rv_req     = 1'b0;
      bus.rv_addr    = '0;
      bus.rv_we      = 1'b0;
      bus.rv_ds      = 2'b00;
      bus.rv_din     = 16'h0000;
      bus.slot_en    = 1'b1;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'h0000;

      test_reset();
      test_write();
      test_read();
      test_null_strobes();
      test_slot_gating();
      test_back_to_back();
      test_timeout();
      test_reset_mid_read();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
